ram_copy_engine: RTL and testbench

- Bus initiator for the 256x16 data RAM. It copies a block of words from one RAM address range to another, or fills a range with a constant, with no processor involvement.
- It issues the same opcode/operand/write_data/read_enable/write_enable command word the RAM already decodes, using REG_OP-class RAM_READ (8'h92) and RAM_WRITE (8'h91) commands.
- An external arbiter muxes this block's bus outputs against the processor's when bus_gnt is high.

---
 rtl/ram_copy_engine.sv | 165 ++++++++++++++++
 tb/tb_ram_copy_engine.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_copy_engine.sv
// RAM copy/fill engine: bus initiator for the 256x16 data RAM.
// Copies a block of words between address ranges, or fills a range with a
// constant. It uses the RAM's existing RAM_READ and RAM_WRITE command words.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | requesting the bus, waiting for grant
// READ  | issuing RAM_READ of cur_src, capturing read_data
// WRITE | issuing RAM_WRITE of cur_dst, advancing pointers
// DONE  | one-cycle completion pulse
module ram_copy_engine #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  mode,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [ADDR_WIDTH:0]   length,
   input  logic [DATA_WIDTH-1:0] fill_value,
   output logic                  bus_req,
   input  logic                  bus_gnt,
   output logic [DATA_WIDTH-1:0] opcode,
   output logic [DATA_WIDTH-1:0] operand,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic                  read_enable,
   output logic                  write_enable,
   input  logic [DATA_WIDTH-1:0] read_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_done
);

   localparam logic [DATA_WIDTH-1:0] OP_RAM_READ  = DATA_WIDTH'(16'h9200);
   localparam logic [DATA_WIDTH-1:0] OP_RAM_WRITE = DATA_WIDTH'(16'h9100);
   // Largest legal job: every address exactly once.
   localparam logic [ADDR_WIDTH:0]   MAX_LEN      = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_READ  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic                  mode_q, mode_d;
   logic [ADDR_WIDTH-1:0] src_q, src_d;
   logic [ADDR_WIDTH-1:0] dst_q, dst_d;
   logic [ADDR_WIDTH:0]   rem_q, rem_d;
   logic [ADDR_WIDTH:0]   wd_q, wd_d;
   logic [DATA_WIDTH-1:0] fill_q, fill_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  error_q, error_d;

   // State and job registers; reset abandons any job in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         mode_q  <= 1'b0;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         wd_q    <= '0;
         fill_q  <= '0;
         data_q  <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         wd_q    <= wd_d;
         fill_q  <= fill_d;
         data_q  <= data_d;
         error_q <= error_d;
      end
   end

   // Next-state, datapath updates and bus command outputs.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      src_d        = src_q;
      dst_d        = dst_q;
      rem_d        = rem_q;
      wd_d         = wd_q;
      fill_d       = fill_q;
      data_d       = data_q;
      error_d      = error_q;
      bus_req      = 1'b0;
      opcode       = '0;
      operand      = '0;
      write_data   = '0;
      read_enable  = 1'b0;
      write_enable = 1'b0;
      done         = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d  = mode;
               src_d   = src_addr;
               dst_d   = dst_addr;
               rem_d   = length;
               fill_d  = fill_value;
               wd_d    = '0;
               error_d = 1'b0;
               if (length == '0) begin
                  state_d = S_DONE;
               end else if (length > MAX_LEN) begin
                  error_d = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            bus_req = 1'b1;
            if (bus_gnt) state_d = mode_q ? S_WRITE : S_READ;
         end
         S_READ: begin
            bus_req = 1'b1;
            if (bus_gnt) begin
               opcode      = OP_RAM_READ;
               operand     = DATA_WIDTH'(src_q);
               read_enable = 1'b1;
               data_d      = read_data;
               state_d     = S_WRITE;
            end
         end
         S_WRITE: begin
            bus_req = 1'b1;
            if (bus_gnt) begin
               opcode       = OP_RAM_WRITE;
               operand      = DATA_WIDTH'(dst_q);
               write_enable = 1'b1;
               write_data   = mode_q ? fill_q : data_q;
               src_d        = src_q + 1'b1;
               dst_d        = dst_q + 1'b1;
               wd_d         = wd_q + 1'b1;
               rem_d        = rem_q - 1'b1;
               if (rem_q == (ADDR_WIDTH+1)'(1)) state_d = S_DONE;
               else if (!mode_q)                state_d = S_READ;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy       = (state_q != S_IDLE);
   assign error      = error_q;
   assign words_done = wd_q;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench for ram_copy_engine with a behavioural 256x16 RAM model.
module tb_ram_copy_engine;
   logic        clk = 1'b0;
   logic        reset, start, mode, bus_gnt;
   logic [7:0]  src_addr, dst_addr;
   logic [8:0]  length;
   logic [15:0] fill_value;
   logic        bus_req, read_enable, write_enable, busy, done, error;
   logic [15:0] opcode, operand, write_data, read_data;
   logic [8:0]  words_done;

   logic [15:0] mem [256];
   logic        pl_en;
   logic [7:0]  pl_addr;
   logic [15:0] pl_data;
   int          we_cnt = 0, re_cnt = 0, done_cnt = 0;
   int          passed = 0, total = 0;

   always #5 clk = ~clk;

   ram_copy_engine dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
      .fill_value(fill_value), .bus_req(bus_req), .bus_gnt(bus_gnt),
      .opcode(opcode), .operand(operand), .write_data(write_data),
      .read_enable(read_enable), .write_enable(write_enable),
      .read_data(read_data), .busy(busy), .done(done), .error(error),
      .words_done(words_done)
   );

   // RAM model: decodes the command word like the real RAM.
   assign read_data = (read_enable && opcode == 16'h9200) ? mem[operand[7:0]] : 16'h0000;

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (write_enable && opcode == 16'h9100) mem[operand[7:0]] <= write_data;
      if (write_enable) we_cnt <= we_cnt + 1;
      if (read_enable)  re_cnt <= re_cnt + 1;
      if (done)         done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic poke(input logic [7:0] a, input logic [15:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic go(input logic m, input logic [7:0] s, input logic [7:0] d,
                     input logic [8:0] len, input logic [15:0] fv);
      mode = m; src_addr = s; dst_addr = d; length = len; fill_value = fv;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Cycle index of the done pulse, counting the start cycle as 0.
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!done && cyc < 300) begin
         tick();
         cyc++;
      end
      chk("done_timeout", {31'd0, done}, 32'd1);
   endtask

   int cyc, we0, re0, dn0, n;

   initial begin
      reset = 1'b1; start = 1'b0; mode = 1'b0; bus_gnt = 1'b1;
      src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      tick(); tick();
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_outs", {27'd0, bus_req, read_enable, write_enable, done, error}, 0);
      chk("rst_opcode", {16'd0, opcode}, 0);
      chk("rst_operand_wd", {operand, 7'd0, words_done}, 0);
      reset = 1'b0;

      // Copy 0x10..0x13 -> 0x80..0x83.
      for (int i = 0; i < 4; i++) poke(8'h10 + 8'(i), 16'hA001 + 16'(i));
      for (int i = 0; i < 4; i++) poke(8'h80 + 8'(i), 16'h0000);
      dn0 = done_cnt;
      go(1'b0, 8'h10, 8'h80, 9'd4, 16'h0);
      chk("copy_busy", {31'd0, busy}, 1);
      wait_done(cyc);
      chk("copy_done_cycle", cyc, 10);
      chk("copy_words_done", {23'd0, words_done}, 4);
      tick();
      chk("copy_busy_after", {30'd0, busy, bus_req}, 0);
      chk("copy_done_once", done_cnt - dn0, 1);
      for (int i = 0; i < 4; i++)
         chk($sformatf("copy_mem_%0h", 8'h80 + i), {16'd0, mem[8'h80 + 8'(i)]}, 32'hA001 + i);

      // Fill with address wrap.
      poke(8'hFE, 16'h0); poke(8'hFF, 16'h0); poke(8'h00, 16'h0); poke(8'h01, 16'h1111);
      we0 = we_cnt;
      go(1'b1, 8'h33, 8'hFE, 9'd3, 16'h5A5A);
      wait_done(cyc);
      chk("fill_done_cycle", cyc, 5);
      chk("fill_we_count", we_cnt - we0, 3);
      tick();
      chk("fill_mem_fe", {16'd0, mem[8'hFE]}, 32'h5A5A);
      chk("fill_mem_ff", {16'd0, mem[8'hFF]}, 32'h5A5A);
      chk("fill_mem_00", {16'd0, mem[8'h00]}, 32'h5A5A);
      chk("fill_mem_01", {16'd0, mem[8'h01]}, 32'h1111);

      // Grant dropped between the first READ and its WRITE.
      poke(8'h30, 16'h1234); poke(8'h31, 16'h5678); poke(8'hB0, 16'h0); poke(8'hB1, 16'h0);
      go(1'b0, 8'h30, 8'hB0, 9'd2, 16'h0);
      n = 0;
      while (!read_enable && n < 20) begin tick(); n++; end
      chk("gap_saw_read", {31'd0, read_enable}, 1);
      chk("gap_read_op", {opcode, operand}, 32'h9200_0030);
      tick();
      bus_gnt = 1'b0;
      poke_free_gap: for (int i = 0; i < 3; i++) begin
         #1;
         chk("gap_strobes", {29'd0, read_enable, write_enable, done}, 0);
         chk("gap_busy_req", {30'd0, busy, bus_req}, 32'h3);
         chk("gap_opcode", {16'd0, opcode}, 0);
         tick();
      end
      bus_gnt = 1'b1;
      wait_done(cyc);
      tick();
      chk("gap_mem_b0", {16'd0, mem[8'hB0]}, 32'h1234);
      chk("gap_mem_b1", {16'd0, mem[8'hB1]}, 32'h5678);

      // Zero length and oversize length.
      we0 = we_cnt; re0 = re_cnt;
      go(1'b0, 8'h10, 8'h50, 9'd0, 16'h0);
      wait_done(cyc);
      chk("len0_done_cycle", cyc, 1);
      chk("len0_error", {31'd0, error}, 0);
      tick();
      go(1'b0, 8'h10, 8'h50, 9'd300, 16'h0);
      wait_done(cyc);
      chk("len300_done_cycle", cyc, 1);
      chk("len300_error", {31'd0, error}, 1);
      tick();
      chk("len300_error_sticky", {31'd0, error}, 1);
      chk("len_bad_no_strobes", (we_cnt - we0) + (re_cnt - re0), 0);
      poke(8'h60, 16'h0);
      go(1'b0, 8'h10, 8'h60, 9'd1, 16'h0);
      chk("error_cleared", {31'd0, error}, 0);
      wait_done(cyc);
      tick();
      chk("len1_mem", {16'd0, mem[8'h60]}, 32'hA001);

      // Reset after 2 of 8 words.
      for (int i = 0; i < 8; i++) poke(8'h20 + 8'(i), 16'hB000 + 16'(i));
      for (int i = 0; i < 8; i++) poke(8'h90 + 8'(i), 16'hDEAD);
      go(1'b0, 8'h20, 8'h90, 9'd8, 16'h0);
      n = 0;
      while (words_done != 9'd2 && n < 40) begin tick(); n++; end
      chk("rst_mid_reached2", {23'd0, words_done}, 2);
      reset = 1'b1;
      tick();
      chk("rst_mid_outs", {25'd0, bus_req, read_enable, write_enable, busy, done, error, 1'b0}, 0);
      chk("rst_mid_bus", {opcode | operand | write_data, 7'd0, words_done}, 0);
      reset = 1'b0;
      tick(); tick();
      for (int i = 0; i < 8; i++)
         chk($sformatf("rst_mid_mem_%0h", 8'h90 + i), {16'd0, mem[8'h90 + 8'(i)]},
             (i < 2) ? 32'hB000 + i : 32'hDEAD);
      go(1'b0, 8'h20, 8'h90, 9'd8, 16'h0);
      wait_done(cyc);
      chk("rst_restart_cycle", cyc, 18);
      tick();
      for (int i = 0; i < 8; i++)
         chk($sformatf("rst_restart_mem_%0h", 8'h90 + i), {16'd0, mem[8'h90 + 8'(i)]}, 32'hB000 + i);

      // Start while busy is ignored.
      for (int i = 0; i < 4; i++) poke(8'h40 + 8'(i), 16'hC001 + 16'(i));
      poke(8'hE0, 16'h7777);
      go(1'b0, 8'h40, 8'hD0, 9'd4, 16'h0);
      tick(); tick();
      go(1'b1, 8'h50, 8'hE0, 9'd2, 16'hFFFF);
      wait_done(cyc);
      chk("busy_start_wd", {23'd0, words_done}, 4);
      chk("busy_start_cycle", cyc, 7);
      tick();
      for (int i = 0; i < 4; i++)
         chk($sformatf("busy_start_mem_%0h", 8'hD0 + i), {16'd0, mem[8'hD0 + 8'(i)]}, 32'hC001 + i);
      chk("busy_start_e0", {16'd0, mem[8'hE0]}, 32'h7777);
      chk("busy_start_idle", {31'd0, busy}, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
